// File: rtl/hazard_control_unit.sv
// hazard_control_unit: forwarding selects, load-use/branch stall/flush control
// and a divider sequencer that stalls the pipeline for DIV_CYCLES cycles.
`default_nettype none

module hazard_control_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_addr_id,
    input  logic [4:0] rs2_addr_id,
    input  logic       rs1_used_id,
    input  logic       rs2_used_id,
    input  logic [4:0] rd_ex,
    input  logic [4:0] rd_ma,
    input  logic [4:0] rd_wb,
    input  logic       reg_write_enable_ex,
    input  logic       reg_write_enable_ma,
    input  logic       reg_write_enable_wb,
    input  logic       mem_read_ex,
    input  logic       div_op_ex,
    input  logic       branch_taken_ex,
    output logic [1:0] forward_rs1,
    output logic [1:0] forward_rs2,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       stall_id_ex,
    output logic       bubble_id_ex,
    output logic       bubble_ex_ma,
    output logic       flush_if_id,
    output logic       div_start,
    output logic       div_busy,
    output logic       div_done
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_next_cnt;
    logic            w_start;
    logic            w_busy;
    logic            w_done;
    logic            w_lu;
    logic [1:0]      w_fwd1;
    logic [1:0]      w_fwd2;

    // A load in EX cannot forward yet, so it is skipped and MA/WB may still supply the operand.
    function automatic logic [1:0] f_fwd_sel(
        input logic [4:0] addr,
        input logic       used,
        input logic [4:0] rdex,
        input logic       weex,
        input logic       ldex,
        input logic [4:0] rdma,
        input logic       wema,
        input logic [4:0] rdwb,
        input logic       wewb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && addr != 5'd0) begin
            if (weex && !ldex && rdex == addr)
                sel = 2'b01;
            else if (wema && rdma == addr)
                sel = 2'b10;
            else if (wewb && rdwb == addr)
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        w_fwd1 = f_fwd_sel(rs1_addr_id, rs1_used_id, rd_ex, reg_write_enable_ex, mem_read_ex,
                           rd_ma, reg_write_enable_ma, rd_wb, reg_write_enable_wb);
        w_fwd2 = f_fwd_sel(rs2_addr_id, rs2_used_id, rd_ex, reg_write_enable_ex, mem_read_ex,
                           rd_ma, reg_write_enable_ma, rd_wb, reg_write_enable_wb);
        w_lu   = mem_read_ex && reg_write_enable_ex && (rd_ex != 5'd0) &&
                 ((rs1_addr_id == rd_ex && rs1_used_id) || (rs2_addr_id == rd_ex && rs2_used_id));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // BUSY leaves when the decremented count reaches zero, giving DIV_CYCLES stall cycles in total.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_start      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (div_op_ex && !branch_taken_ex) begin
                    w_start      = 1'b1;
                    w_busy       = 1'b1;
                    w_next_cnt   = CW'(DIV_CYCLES - 1);
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy     = 1'b1;
                w_next_cnt = r_cnt - CW'(1);
                if (r_cnt <= CW'(1))
                    w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        forward_rs1  = w_fwd1;
        forward_rs2  = w_fwd2;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        bubble_id_ex = 1'b0;
        bubble_ex_ma = 1'b0;
        flush_if_id  = 1'b0;
        div_start    = w_start;
        div_busy     = w_busy;
        div_done     = w_done;
        if (w_busy) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            bubble_ex_ma = 1'b1;
        end else if (branch_taken_ex) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (w_lu) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end
        if (reset) begin
            forward_rs1  = 2'b00;
            forward_rs2  = 2'b00;
            stall_pc     = 1'b0;
            stall_if_id  = 1'b0;
            stall_id_ex  = 1'b0;
            bubble_id_ex = 1'b0;
            bubble_ex_ma = 1'b0;
            flush_if_id  = 1'b0;
            div_start    = 1'b0;
            div_busy     = 1'b0;
            div_done     = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed scenarios plus randomized cycles checked
// against a cycle-count reference model of the hazard controller.
`default_nettype none

module tb_hazard_control_unit;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       r_reset;
    logic [4:0] r_rs1, r_rs2, r_rd_ex, r_rd_ma, r_rd_wb;
    logic       r_u1, r_u2, r_we_ex, r_we_ma, r_we_wb, r_mr, r_div, r_br;
    logic [1:0] w_f1, w_f2;
    logic       w_spc, w_sifid, w_sidex, w_bidex, w_bexma, w_flush, w_dstart, w_dbusy, w_ddone;

    int errors = 0;
    int checks = 0;
    int k      = 0;   // cycles elapsed since divide start; 0 = no divide in progress

    hazard_control_unit #(.DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(r_reset),
        .rs1_addr_id(r_rs1), .rs2_addr_id(r_rs2),
        .rs1_used_id(r_u1), .rs2_used_id(r_u2),
        .rd_ex(r_rd_ex), .rd_ma(r_rd_ma), .rd_wb(r_rd_wb),
        .reg_write_enable_ex(r_we_ex), .reg_write_enable_ma(r_we_ma),
        .reg_write_enable_wb(r_we_wb),
        .mem_read_ex(r_mr), .div_op_ex(r_div), .branch_taken_ex(r_br),
        .forward_rs1(w_f1), .forward_rs2(w_f2),
        .stall_pc(w_spc), .stall_if_id(w_sifid), .stall_id_ex(w_sidex),
        .bubble_id_ex(w_bidex), .bubble_ex_ma(w_bexma), .flush_if_id(w_flush),
        .div_start(w_dstart), .div_busy(w_dbusy), .div_done(w_ddone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] a, input logic u);
        if (!u || a == 0) return 2'd0;
        if (r_we_ex && !r_mr && r_rd_ex == a) return 2'd1;
        if (r_we_ma && r_rd_ma == a) return 2'd2;
        if (r_we_wb && r_rd_wb == a) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic ref_start();
        return (k == 0) && r_div && !r_br;
    endfunction

    // {fwd1, fwd2, stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, bubble_ex_ma, flush, start, busy, done}
    function automatic logic [12:0] ref_vec();
        logic st, busy, done, lu;
        logic [8:0] c;
        if (r_reset) return 13'd0;
        st   = ref_start();
        busy = st || (k >= 1 && k < DIV);
        done = (k == DIV);
        lu   = r_mr && r_we_ex && r_rd_ex != 0 &&
               ((r_rs1 == r_rd_ex && r_u1) || (r_rs2 == r_rd_ex && r_u2));
        if (busy)      c = 9'b111_0_1_0_000;
        else if (r_br) c = 9'b000_1_0_1_000;
        else if (lu)   c = 9'b110_1_0_0_000;
        else           c = 9'b0;
        c[2] = st; c[1] = busy; c[0] = done;
        return {ref_fwd(r_rs1, r_u1), ref_fwd(r_rs2, r_u2), c};
    endfunction

    task automatic sample(input string tag);
        @(negedge clk);
        check(tag, {19'd0, w_f1, w_f2, w_spc, w_sifid, w_sidex, w_bidex, w_bexma,
                    w_flush, w_dstart, w_dbusy, w_ddone}, {19'd0, ref_vec()});
    endtask

    task automatic advance();
        @(posedge clk);
        if (r_reset)                k = 0;
        else if (k == 0)            k = ref_start() ? 1 : 0;
        else if (k < DIV)           k = k + 1;
        else                        k = 0;
        #1;
    endtask

    task automatic clear_inputs();
        {r_rs1, r_rs2, r_rd_ex, r_rd_ma, r_rd_wb} = '0;
        {r_u1, r_u2, r_we_ex, r_we_ma, r_we_wb, r_mr, r_div, r_br} = '0;
    endtask

    initial begin
        clear_inputs();
        r_reset = 1'b1;
        r_rs1 = 5'd5; r_u1 = 1'b1; r_rd_ex = 5'd5; r_we_ex = 1'b1;
        sample("reset_vec");
        check("reset_fwd1", {30'd0, w_f1}, 32'd0);
        advance();
        advance();
        r_reset = 1'b0;

        // forwarding priority
        r_rd_ma = 5'd5; r_rd_wb = 5'd5; r_we_ma = 1'b1; r_we_wb = 1'b1;
        sample("fwd_all");   check("fwd_ex", {30'd0, w_f1}, 32'd1); advance();
        r_we_ex = 1'b0;
        sample("fwd_mawb");  check("fwd_ma", {30'd0, w_f1}, 32'd2); advance();
        r_rs1 = 5'd0;
        sample("fwd_zero");  check("fwd_x0", {30'd0, w_f1}, 32'd0); advance();

        // load-use then forward from MA
        clear_inputs();
        r_mr = 1'b1; r_we_ex = 1'b1; r_rd_ex = 5'd7; r_rs2 = 5'd7; r_u2 = 1'b1;
        sample("lu_vec");
        check("lu_stall", {29'd0, w_spc, w_sifid, w_bidex}, 32'h7);
        advance();
        r_mr = 1'b0; r_rd_ex = 5'd0; r_we_ex = 1'b0; r_rd_ma = 5'd7; r_we_ma = 1'b1;
        sample("lu_next");
        check("lu_fwd_ma", {29'd0, w_f2, w_spc}, {29'd0, 2'd2, 1'b0});
        advance();

        // branch beats load-use
        clear_inputs();
        r_mr = 1'b1; r_we_ex = 1'b1; r_rd_ex = 5'd7; r_rs2 = 5'd7; r_u2 = 1'b1; r_br = 1'b1;
        sample("br_vec");
        check("br_ctl", {29'd0, w_flush, w_bidex, w_spc}, 32'h6);
        advance();

        // divide held from T, second divide from T+5
        clear_inputs();
        r_div = 1'b1;
        for (int t = 0; t <= 9; t++) begin
            sample($sformatf("div_t%0d", t));
            check($sformatf("div_start_t%0d", t), {31'd0, w_dstart}, {31'd0, t == 0 || t == 5});
            check($sformatf("div_done_t%0d", t),  {31'd0, w_ddone},  {31'd0, t == 4 || t == 9});
            check($sformatf("div_stall_t%0d", t), {31'd0, w_spc},    {31'd0, t != 4 && t != 9});
            if (t == 9) r_div = 1'b0;
            advance();
        end

        // reset in the middle of a divide
        r_div = 1'b1;
        sample("rst_t0"); advance();
        r_div = 1'b0;
        sample("rst_t1"); advance();
        r_reset = 1'b1;
        sample("rst_t2");
        check("rst_busy", {31'd0, w_dbusy}, 32'd0);
        advance();
        r_reset = 1'b0;
        for (int t = 3; t <= 8; t++) begin
            sample($sformatf("rst_t%0d", t));
            check($sformatf("rst_done_t%0d", t), {30'd0, w_dbusy, w_ddone}, 32'd0);
            advance();
        end

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r_reset = ($urandom_range(0, 59) == 0);
            r_rs1   = 5'($urandom_range(0, 3));
            r_rs2   = 5'($urandom_range(0, 3));
            r_rd_ex = 5'($urandom_range(0, 3));
            r_rd_ma = 5'($urandom_range(0, 3));
            r_rd_wb = 5'($urandom_range(0, 3));
            {r_u1, r_u2, r_we_ex, r_we_ma, r_we_wb} = 5'($urandom);
            r_mr  = ($urandom_range(0, 2) == 0);
            r_div = ($urandom_range(0, 7) == 0);
            r_br  = ($urandom_range(0, 5) == 0);
            sample($sformatf("rand_%0d", n));
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_control_unit.md
# hazard_control_unit

Central hazard controller for the RV32IM five-stage pipeline. Each cycle it produces the rs1/rs2 forwarding selects consumed by the ID-stage forwarding mux. It also detects load-use hazards, flushes on taken branches, and runs a cycle counter that stalls the pipeline while the iterative divider in EX finishes. All stall, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MA registers come from this block.

## Interface
- DIV_CYCLES, 32, number of cycles the divider needs after `div_start`; legal range 2..64.
- clk  input  1  pipeline clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- rs1_addr_id, rs2_addr_id  input  5  source registers of the instruction in ID
- rs1_used_id, rs2_used_id  input  1  the instruction in ID actually reads rs1/rs2
- rd_ex, rd_ma, rd_wb  input  5  destination registers in EX/MA/WB
- reg_write_enable_ex, reg_write_enable_ma, reg_write_enable_wb  input  1  write enables per stage
- mem_read_ex  input  1  instruction in EX is a load
- div_op_ex  input  1  instruction in EX is DIV/DIVU/REM/REMU
- branch_taken_ex  input  1  branch or jump resolved taken in EX
- forward_rs1, forward_rs2  output  2  00 = register file, 01 = EX, 10 = MA, 11 = WB
- stall_pc, stall_if_id, stall_id_ex  output  1  hold the register
- bubble_id_ex  output  1  load NOP into ID/EX
- bubble_ex_ma  output  1  load NOP into EX/MA
- flush_if_id  output  1  load NOP into IF/ID
- div_start  output  1  one-cycle start pulse to the divider
- div_busy  output  1  divider sequence in progress
- div_done  output  1  divider result valid; EX/MA captures it this cycle

## Operation
- **Forward select (per operand X in {rs1, rs2}).**
  - The select is 00 if `X_used_id`=0 or the address is 0.
  - Otherwise the priority is EX > MA > WB.
  - An EX match requires `reg_write_enable_ex`=1 and `mem_read_ex`=0.
  - If EX is a load, the select falls through to MA or WB, or to 00.
- **Load-use.** `lu` = `mem_read_ex` & `reg_write_enable_ex` & (`rd_ex`≠0) & (rs1 match & `rs1_used_id` | rs2 match & `rs2_used_id`).
  - When `lu` is set: `stall_pc`=`stall_if_id`=1 and `bubble_id_ex`=1 for exactly one cycle.
  - The following cycle, the load is in MA and the select is 10.
- **Branch.** When `branch_taken_ex`=1: `flush_if_id`=1 and `bubble_id_ex`=1. `lu` is ignored that cycle, because flush takes precedence over load-use.
- **Divider FSM.** States are IDLE, BUSY and DONE. The counter width is clog2(DIV_CYCLES+1).
  - **IDLE:** if `div_op_ex`=1 and `branch_taken_ex`=0: `div_start`=1, counter ← DIV_CYCLES-1, next state BUSY. The stall is already asserted in this cycle.
  - **BUSY:** counter decrements. Move to DONE when counter = 0 is seen at the edge; otherwise stay in BUSY.
  - **DONE:** `div_done`=1, no stall, next state IDLE unconditionally. `div_op_ex` is ignored in DONE, so the same instruction cannot restart the divider.
  - `div_busy`=1 in the IDLE-start cycle and in BUSY.
- **Divider stall.** While `div_busy`=1: `stall_pc`=`stall_if_id`=`stall_id_ex`=1 and `bubble_ex_ma`=1.
  - `lu` and the branch flush are both masked during the divider stall.
  - The EX instruction is the divide, so `branch_taken_ex` cannot legitimately be set then.
- **Priority.** div stall > branch flush > load-use > none.

## Timing
- Forward selects and load-use/branch controls are combinational from the current inputs, with zero latency.
- **Reset.** On the edge where `reset`=1: state ← IDLE and counter ← 0.
  - While `reset`=1, every output is forced to 0, including the forward selects (00).
- **Divide in EX at cycle T:**
  - Stall is asserted during cycles T .. T+DIV_CYCLES-1 (DIV_CYCLES cycles).
  - `div_done` is asserted at T+DIV_CYCLES.
  - The divide leaves EX on the edge ending T+DIV_CYCLES, so it occupies EX for DIV_CYCLES+1 cycles.
- **Back-to-back divides.** A second divide reaching EX at T+DIV_CYCLES+1 starts immediately from IDLE.
- **Reset mid-BUSY.** The FSM returns to IDLE on that edge, and `div_busy` is 0 on the next cycle.
- **Simultaneous matches.** When EX, MA and WB all match, the select is 01. When only MA and WB match, it is 10.

## Test plan
- **Forward priority.** rs1=5, used; `rd_ex`=`rd_ma`=`rd_wb`=5, all write-enabled, `mem_read_ex`=0 → `forward_rs1`=01. Then drop `reg_write_enable_ex` → 10. Then set rs1=0 → 00.
- **Load-use.** `mem_read_ex`=1, `rd_ex`=7, rs2=7, `rs2_used_id`=1 → `stall_pc`, `stall_if_id` and `bubble_id_ex` are 1 for one cycle. The next cycle, with `rd_ma`=7, gives `forward_rs2`=10 and no stall.
- **Branch vs load-use.** `branch_taken_ex`=1 in the same cycle as a load-use match → `flush_if_id`=1, `bubble_id_ex`=1, `stall_pc`=0.
- **Divide with DIV_CYCLES=4.** `div_op_ex` held at 1 from cycle T → `div_start` pulses at T only. Stall is high for T..T+3, `div_done` is high at T+4, and stall is 0 at T+4.
- **Back-to-back divide.** A second divide follows at T+5 → new `div_start` at T+5, and `div_done` at T+9.
- **Reset mid-divide.** `reset`=1 at T+2 → all outputs are 0 that cycle, the FSM is IDLE at T+3, and `div_done` never asserts.
